wb_queue: RTL and testbench
===========================

# wb_queue

Write-back queue that acts as the initiator side of the register-file write port. It accepts completed results (destination register plus data) from the execute/load stages over a valid/ready handshake, buffers them in order, and drains one entry per cycle into the register file's `w_en`/`rd`/`w_data` port. While results are waiting, it forwards pending values to the two operand-read addresses, so readers never see stale register-file contents.

## Interface
- `DEPTH`, 4: queue entries; a power of two, at least 2.
- `XLEN`, 32: data width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: the producer offers a result.
- `in_ready`  out  1: the queue can accept a result this cycle.
- `in_rd`  in  5: destination register of the offered result.
- `in_data`  in  XLEN: result value.
- `wb_hold`  in  1: pauses draining (write port is borrowed elsewhere).
- `w_en`  out  1: register-file write enable.
- `w_rd`  out  5: register-file write address.
- `w_data`  out  XLEN: register-file write data.
- `rs1`, `rs2`  in  5 each: operand read addresses, also sent to the register file.
- `fwd1_hit`, `fwd2_hit`  out  1 each: a pending queue entry matches `rs1` / `rs2`.
- `fwd1_data`, `fwd2_data`  out  XLEN each: value of the youngest matching entry.
- `count`  out  $clog2(DEPTH+1): number of occupied entries.
- `empty`  out  1: `count == 0`.

## Operation
- The queue is a circular FIFO with a head pointer, a tail pointer and an occupancy counter. Pointers wrap modulo `DEPTH`.
- **Accept:** a transfer occurs when `in_valid && in_ready`.
  - `in_ready = (count != DEPTH)`. It is derived from registered state only and does not depend on a same-cycle pop.
  - A transfer with `in_rd == 0` completes the handshake but is not enqueued (x0 writes are dropped).
  - Otherwise `{in_rd, in_data}` is written at the tail and the tail advances.
- **Drain:** `w_en = !empty && !wb_hold`. `w_rd` and `w_data` always show the head entry, and are 0 when the queue is empty. When `w_en` is high, the head pops at the clock edge.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance. When full, no push is accepted even if a pop happens in the same cycle.
- **Forwarding:**
  - For each read port, search all occupied entries for `rd == rsN`. Report the youngest match (the one closest to the tail).
  - `rsN == 0` never hits.
  - The entry being drained this cycle still forwards. After the edge, the register file holds its value.
  - The current incoming `in_*` is not forwarded in the same cycle.
  - On a miss, `fwdN_data = 0`.
- **Reset:** `rst` high clears both pointers and `count` at the next edge, discarding any entries in flight. No write is issued in that cycle after reset takes effect.

## Timing
- Reset values: `count = 0`, `empty = 1`, `in_ready = 1`, `w_en = 0`, `w_rd = 0`, `w_data = 0`, `fwdN_hit = 0`, `fwdN_data = 0`.
- Enqueue-to-write latency is 1 cycle minimum. A result accepted at edge N is presented on `w_*` during cycle N+1, provided it is the head and `wb_hold` is low. The register file commits it at edge N+2.
- `w_*`, `fwd*` and `in_ready` are combinational from registered state plus `wb_hold` / `rs1` / `rs2`. There is no input-to-output path from `in_*`.
- Throughput: one accept and one drain per cycle, sustained.
- Forwarding visibility: a result accepted at edge N is visible on `fwd*` from cycle N+1 until the edge at which it pops.

## Structure
- Shared package `rv32_pkg` holds:
  - `REG_ADDR_W = 5` and `XLEN = 32`;
  - typedef `wb_entry_t` as a packed struct of `rd` (5 bits) and `data` (XLEN bits).
- One sub-module, `wb_fwd_lookup`: a combinational youngest-match priority search over the entry array, head pointer and count for a single read address. It is instantiated twice, once per read port.
- Storage is a `wb_entry_t` array of `DEPTH` entries, written only on push. No reset of the array contents is needed; valid bits are derived from head and count.

## Test plan
- **Reset, single result, idle:** after reset, push `{rd=5, 0xDEADBEEF}` → the next cycle shows `w_en=1`, `w_rd=5`, `w_data=0xDEADBEEF`; the cycle after shows `empty=1` and `w_en=0`.
- **Fill under hold:** hold `wb_hold=1` and push 5 results with `DEPTH=4` → `in_ready` drops after the 4th push and `count=4`. Release the hold → writes drain in push order over 4 consecutive cycles.
- **Forwarding priority:** under hold, push `{3, 0x11}` then `{3, 0x22}`, and set `rs1=3`, `rs2=4` → `fwd1_hit=1`, `fwd1_data=0x22`, `fwd2_hit=0`. After both drain → `fwd1_hit=0`.
- **x0 drop:** push `{0, 0x55}` → the handshake completes, `count` stays 0, no `w_en`, and `rs1=0` gives no hit.
- **Full with simultaneous pop:** full queue, `wb_hold=0`, `in_valid=1` → no accept that cycle, `count` goes 4→3, and `in_ready=1` the next cycle.
- **Reset mid-operation:** with 3 entries pending, assert `rst` for one cycle → `count=0`, `w_en=0`, `fwd*_hit=0`, and none of the discarded entries are ever written.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared register-file widths and write-back entry type
package rv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// rtl/wb_fwd_lookup.sv - youngest-match search of pending write-back entries for one read address
module wb_fwd_lookup
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  wb_entry_t             entries [DEPTH],
  input  logic [PTR_W-1:0]      head,
  input  logic [CNT_W-1:0]      count,
  input  logic [REG_ADDR_W-1:0] rs,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest; x0 never matches.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (rs != '0) && (entries[idx].rd == rs)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order write-back queue draining into the register-file write port with operand forwarding
module wb_queue
  import rv32_pkg::wb_entry_t;
  import rv32_pkg::REG_ADDR_W;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REG_ADDR_W-1:0]        in_rd,
  input  logic [XLEN-1:0]              in_data,
  input  logic                         wb_hold,
  output logic                         w_en,
  output logic [REG_ADDR_W-1:0]        w_rd,
  output logic [XLEN-1:0]              w_data,
  input  logic [REG_ADDR_W-1:0]        rs1,
  input  logic [REG_ADDR_W-1:0]        rs2,
  output logic                         fwd1_hit,
  output logic                         fwd2_hit,
  output logic [XLEN-1:0]              fwd1_data,
  output logic [XLEN-1:0]              fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        head_entry;
  wb_entry_t        wr_entry;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy, so a full queue refuses even when it pops this cycle.
  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign push       = in_valid && in_ready && (in_rd != '0);
  assign pop        = w_en;
  assign w_en       = !empty && !wb_hold;
  assign head_entry = mem_q[head_q];
  assign w_rd       = empty ? '0 : head_entry.rd;
  assign w_data     = empty ? '0 : head_entry.data;
  assign wr_entry   = '{rd: in_rd, data: in_data};

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written only on push; validity comes from head and count.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[tail_q] <= wr_entry;
  end

  wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (mem_q),
    .head    (head_q),
    .count   (count_q),
    .rs      (rs1),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (mem_q),
    .head    (head_q),
    .count   (count_q),
    .rs      (rs2),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - randomized and directed bench for wb_queue against a queue-based reference model
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        w_en;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fails  = 0;

  int          mq_rd[$];
  logic [31:0] mq_data[$];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .wb_hold   (wb_hold),
    .w_en      (w_en),
    .w_rd      (w_rd),
    .w_data    (w_data),
    .rs1       (rs1),
    .rs2       (rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count),
    .empty     (empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the pending list: oldest at index 0, youngest at the end.
  task automatic model_check();
    int          sz;
    logic        h1, h2;
    logic [31:0] d1, d2;
    sz = mq_rd.size();
    h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    for (int i = 0; i < sz; i++) begin
      if (rs1 != 0 && mq_rd[i] == int'(rs1)) begin h1 = 1'b1; d1 = mq_data[i]; end
      if (rs2 != 0 && mq_rd[i] == int'(rs2)) begin h2 = 1'b1; d2 = mq_data[i]; end
    end
    chk("count",     64'(count),     64'(sz));
    chk("empty",     64'(empty),     64'(sz == 0));
    chk("in_ready",  64'(in_ready),  64'(sz != DEPTH));
    chk("w_en",      64'(w_en),      64'(sz != 0 && !wb_hold));
    chk("w_rd",      64'(w_rd),      (sz != 0) ? 64'(mq_rd[0]) : 64'd0);
    chk("w_data",    64'(w_data),    (sz != 0) ? 64'(mq_data[0]) : 64'd0);
    chk("fwd1_hit",  64'(fwd1_hit),  64'(h1));
    chk("fwd1_data", 64'(fwd1_data), 64'(d1));
    chk("fwd2_hit",  64'(fwd2_hit),  64'(h2));
    chk("fwd2_data", 64'(fwd2_data), 64'(d2));
  endtask

  task automatic model_update();
    int sz;
    bit acc, pop;
    sz = mq_rd.size();
    if (rst) begin
      mq_rd.delete();
      mq_data.delete();
    end else begin
      acc = in_valid && (sz != DEPTH);
      pop = (sz != 0) && !wb_hold;
      if (pop) begin
        void'(mq_rd.pop_front());
        void'(mq_data.pop_front());
      end
      if (acc && in_rd != 0) begin
        mq_rd.push_back(int'(in_rd));
        mq_data.push_back(in_data);
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [4:0] rd, input logic [31:0] d,
                      input logic h, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst = r; in_valid = v; in_rd = rd; in_data = d; wb_hold = h; rs1 = a; rs2 = b;
    #1;
    model_check();
    model_update();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; wb_hold = 1'b0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);

    // reset state
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_w_en", 64'(w_en), 0);
    chk("rst_w_data", 64'(w_data), 0);
    chk("rst_fwd1_hit", 64'(fwd1_hit), 0);

    // single result, one-cycle latency
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("single_w_en", 64'(w_en), 1);
    chk("single_w_rd", 64'(w_rd), 5);
    chk("single_w_data", 64'(w_data), 64'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("single_empty", 64'(empty), 1);
    chk("single_w_en_off", 64'(w_en), 0);

    // fill under hold, then drain in order
    for (int i = 0; i < 5; i++) step(0, 1, 5'(i + 1), 32'h100 + 32'(i), 1, 0, 0);
    chk("fill_in_ready", 64'(in_ready), 0);
    chk("fill_count", 64'(count), 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("drain_w_en", 64'(w_en), 1);
      chk("drain_w_rd", 64'(w_rd), 64'(i + 1));
      chk("drain_w_data", 64'(w_data), 64'(32'h100 + 32'(i)));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drain_empty", 64'(empty), 1);

    // forwarding priority
    step(0, 1, 3, 32'h11, 1, 0, 0);
    step(0, 1, 3, 32'h22, 1, 0, 0);
    step(0, 0, 0, 0, 1, 3, 4);
    chk("fwd_prio_hit", 64'(fwd1_hit), 1);
    chk("fwd_prio_data", 64'(fwd1_data), 64'h22);
    chk("fwd_other_miss", 64'(fwd2_hit), 0);
    step(0, 0, 0, 0, 0, 3, 4);
    chk("fwd_while_pop_data", 64'(fwd1_data), 64'h22);
    step(0, 0, 0, 0, 0, 3, 4);
    chk("fwd_last_drain_hit", 64'(fwd1_hit), 1);
    step(0, 0, 0, 0, 0, 3, 4);
    chk("fwd_after_drain", 64'(fwd1_hit), 0);

    // x0 writes are dropped
    step(0, 1, 0, 32'h55, 0, 0, 0);
    chk("x0_in_ready", 64'(in_ready), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("x0_count", 64'(count), 0);
    chk("x0_w_en", 64'(w_en), 0);
    chk("x0_fwd", 64'(fwd1_hit), 0);

    // full with simultaneous pop: no accept
    for (int i = 0; i < 4; i++) step(0, 1, 5'(8 + i), 32'h200 + 32'(i), 1, 0, 0);
    step(0, 1, 20, 32'h300, 0, 20, 0);
    chk("fullpop_in_ready", 64'(in_ready), 0);
    chk("fullpop_count", 64'(count), 4);
    step(0, 0, 0, 0, 1, 20, 9);
    chk("fullpop_count_after", 64'(count), 3);
    chk("fullpop_ready_after", 64'(in_ready), 1);
    chk("fullpop_not_enq", 64'(fwd1_hit), 0);

    // reset with three pending entries
    step(1, 0, 0, 0, 0, 9, 10);
    step(0, 0, 0, 0, 0, 9, 10);
    chk("midrst_count", 64'(count), 0);
    chk("midrst_w_en", 64'(w_en), 0);
    chk("midrst_fwd1", 64'(fwd1_hit), 0);
    chk("midrst_fwd2", 64'(fwd2_hit), 0);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) < 7),
           5'($urandom_range(0, 7)),
           $urandom(),
           ($urandom_range(0, 9) < 3),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
